// File: rtl/arith_serial_ctrl.sv
// Bit-serial sequencer for a shared 1-bit arithmetic slice: steps WIDTH-bit
// operands LSB-first through the slice and assembles result, carry and overflow.
module arith_serial_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin_init,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             au_s1,
    output logic             au_s0,
    output logic             au_a,
    output logic             au_b,
    output logic             au_cin,
    input  logic             au_f,
    input  logic             au_cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_shift;
    logic [1:0]       op_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, transfer, ins_bit, carry_next;

    assign accept     = start && (state != RUN);
    assign transfer   = (op_q == 2'b00);
    // Transfer bypasses the slice entirely and keeps the carry chain at zero
    assign ins_bit    = transfer ? a_sr[0] : au_f;
    assign carry_next = transfer ? 1'b0 : au_cout;
    assign res_shift  = {ins_bit, res_sr};

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        au_s1      = 1'b0;
        au_s0      = 1'b0;
        au_a       = 1'b0;
        au_b       = 1'b0;
        au_cin     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                au_s1  = op_q[1];
                au_s0  = op_q[0];
                au_a   = a_sr[0];
                au_b   = b_sr[0];
                au_cin = carry;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            op_q   <= 2'b00;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                res_sr <= '0;
                op_q   <= op;
                carry  <= (op == 2'b00) ? 1'b0 : cin_init;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= res_shift[WIDTH-1:1];
                carry  <= carry_next;
                cnt    <= cnt + CW'(1);
                // On the last bit, carry still holds the carry into the MSB
                if (cnt == LAST) begin
                    result <= res_shift;
                    cout   <= carry_next;
                    ovf    <= transfer ? 1'b0 : (carry ^ carry_next);
                end
            end
        end
    end

endmodule

// File: tb/tb_arith_serial_ctrl.sv
// Self-checking bench for arith_serial_ctrl: models the 1-bit slice and compares
// outcomes against a word-level arithmetic reference model.
module tb_arith_serial_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, start, cin_init;
    logic [1:0]   op;
    logic [W-1:0] a, b, result;
    logic         busy, done, cout, ovf;
    logic         au_s1, au_s0, au_a, au_b, au_cin, au_f, au_cout;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    arith_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cin_init(cin_init), .busy(busy), .done(done), .result(result),
        .cout(cout), .ovf(ovf), .au_s1(au_s1), .au_s0(au_s0), .au_a(au_a),
        .au_b(au_b), .au_cin(au_cin), .au_f(au_f), .au_cout(au_cout)
    );

    // Behavioural model of the shared arithmetic slice
    always_comb begin
        logic x, y;
        x = au_s1 & au_s0 ? ~au_a : au_a;
        y = au_s1 & ~au_s0 ? ~au_b : au_b;
        if ({au_s1, au_s0} == 2'b00) begin
            au_f    = au_a;
            au_cout = 1'b0;
        end else begin
            au_f    = x ^ y ^ au_cin;
            au_cout = (x & y) | (x & au_cin) | (y & au_cin);
        end
    end

    // Word-level reference: returns {ovf, cout, result}
    function automatic logic [W+1:0] model(input logic [1:0] o, input logic [W-1:0] x0,
                                           input logic [W-1:0] y0, input logic ci);
        logic [W-1:0] x, y;
        logic [W:0]   sum;
        logic [W-1:0] low;
        if (o == 2'b00) return {2'b00, x0};
        x   = (o == 2'b11) ? ~x0 : x0;
        y   = (o == 2'b10) ? ~y0 : y0;
        sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        low = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, ci};
        return {low[W-1] ^ sum[W], sum[W], sum[W-1:0]};
    endfunction

    // Launches one operation, scrambles the operand inputs during RUN, and
    // returns at the negedge where done is first seen (or the bound expires)
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic ci, output int busy_cnt, output logic got_done,
                          output logic [1:0] s_seen);
        int guard;
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb; cin_init = ci;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 4'($urandom); b = 4'($urandom); op = 2'($urandom); cin_init = 1'($urandom);
        s_seen = {au_s1, au_s0};
        busy_cnt = 0;
        guard = 0;
        while (!done && guard < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            guard++;
        end
        got_done = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; cin_init = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, cout, ovf} !== 4'b0000) $display("[TB] FAIL reset_flags got %b exp 0000", {busy, done, cout, ovf});
        else passed++;
        checks++;
        if (result !== '0) $display("[TB] FAIL reset_result got %h exp 0", result);
        else passed++;
        checks++;
        if ({au_s1, au_s0, au_a, au_b, au_cin} !== 5'b0) $display("[TB] FAIL reset_au got %b exp 00000", {au_s1, au_s0, au_a, au_b, au_cin});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_directed(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic ci, input string name);
        int busy_cnt;
        logic got_done;
        logic [1:0] s_seen;
        logic [W+1:0] exp;
        exp = model(o, aa, bb, ci);
        run_op(o, aa, bb, ci, busy_cnt, got_done, s_seen);
        checks++;
        if (!got_done || busy_cnt != W) $display("[TB] FAIL %s_latency got done=%b busy=%0d exp done=1 busy=%0d", name, got_done, busy_cnt, W);
        else passed++;
        checks++;
        if ({ovf, cout, result} !== exp) $display("[TB] FAIL %s_result got ovf=%b cout=%b res=%b exp %b", name, ovf, cout, result, exp);
        else passed++;
        checks++;
        if (s_seen !== o) $display("[TB] FAIL %s_sel_run got %b exp %b", name, s_seen, o);
        else passed++;
        checks++;
        if ({au_s1, au_s0} !== 2'b00) $display("[TB] FAIL %s_sel_done got %b exp 00", name, {au_s1, au_s0});
        else passed++;
    endtask

    task automatic test_back_to_back();
        int busy_cnt, guard;
        logic got_done;
        logic [1:0] s_seen;
        run_op(2'b11, 4'b0011, 4'b0010, 1'b1, busy_cnt, got_done, s_seen);
        checks++;
        if (!got_done || result !== 4'b1111 || cout !== 1'b0) $display("[TB] FAIL b2b_first got done=%b res=%b cout=%b exp 1 1111 0", got_done, result, cout);
        else passed++;
        start = 1'b1; op = 2'b00; a = 4'b1010; b = 4'($urandom); cin_init = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 4'($urandom);
        checks++;
        if (busy !== 1'b1 || result !== 4'b1111) $display("[TB] FAIL b2b_gap got busy=%b res=%b exp 1 1111", busy, result);
        else passed++;
        guard = 0;
        while (!done && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!done || {ovf, cout, result} !== 6'b00_1010) $display("[TB] FAIL b2b_second got done=%b ovf=%b cout=%b res=%b exp 1 0 0 1010", done, ovf, cout, result);
        else passed++;
    endtask

    task automatic test_start_ignored();
        int busy_cnt, guard;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 4'b0101; b = 4'b0011; cin_init = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (!done && guard < 20) begin
            if (busy) begin
                busy_cnt++;
                start = (busy_cnt == 3);
                if (busy_cnt == 3) a = 4'b1111;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        checks++;
        if (!done || busy_cnt != W || result !== 4'b1000) $display("[TB] FAIL ignore_start got done=%b busy=%0d res=%b exp 1 %0d 1000", done, busy_cnt, result, W);
        else passed++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL ignore_not_queued got busy=%b done=%b exp 0 0", busy, done);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int busy_cnt, guard;
        logic saw_done;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 4'b0101; b = 4'b0011; cin_init = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (busy_cnt < 3 && guard < 20) begin
            if (busy) busy_cnt++;
            if (busy_cnt < 3) @(negedge clk);
            guard++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00 || result !== '0) $display("[TB] FAIL rst_run got busy=%b done=%b res=%b exp 0 0 0000", busy, done, result);
        else passed++;
        checks++;
        if ({au_s1, au_s0, au_a, au_b, au_cin} !== 5'b0) $display("[TB] FAIL rst_run_au got %b exp 00000", {au_s1, au_s0, au_a, au_b, au_cin});
        else passed++;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) $display("[TB] FAIL rst_run_no_done got %b exp 0", saw_done);
        else passed++;
    endtask

    task automatic test_random();
        int busy_cnt;
        logic got_done;
        logic [1:0] s_seen, o;
        logic [W-1:0] aa, bb;
        logic ci;
        logic [W+1:0] exp;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom); aa = 4'($urandom); bb = 4'($urandom); ci = 1'($urandom);
            exp = model(o, aa, bb, ci);
            run_op(o, aa, bb, ci, busy_cnt, got_done, s_seen);
            checks++;
            if (!got_done || busy_cnt != W || {ovf, cout, result} !== exp)
                $display("[TB] FAIL random_%0d op=%b a=%b b=%b cin=%b got done=%b busy=%0d ovf/cout/res=%b exp %b",
                         i, o, aa, bb, ci, got_done, busy_cnt, {ovf, cout, result}, exp);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed(2'b01, 4'b0101, 4'b0011, 1'b0, "add_ovf");
        test_directed(2'b10, 4'b0111, 4'b0010, 1'b1, "sub");
        test_directed(2'b01, 4'b1111, 4'b0001, 1'b0, "wrap");
        test_directed(2'b00, 4'b0110, 4'b1001, 1'b1, "transfer");
        test_back_to_back();
        test_start_ignored();
        test_random();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
